goldschmidt_div: RTL and testbench
==================================

Name: goldschmidt_div

Overview:
- Parametrised, self-sequencing Goldschmidt divider.
- Owns its N/D/K registers, iteration counter and control FSM, and reuses one shared multiplier for both the N and D updates.
- Accepts a normalised divisor and an initial reciprocal approximation (IA) through a start/busy/done handshake.
- Returns the quotient after a parametrised number of iterations and flags divide-by-zero.

Parameters:
- WIDTH, 16, operand/result width; all data are unsigned fixed point Q1.(WIDTH-1).
- ITER, 3, Goldschmidt iterations per divide (1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- N  input  WIDTH  numerator, range [0,1).
- D  input  WIDTH  divisor, normalised to [0.5,1); 0 is legal (dbz).
- IA  input  WIDTH  initial approximation of 1/D, range (1,2).
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse; q and dbz valid.
- q  output  WIDTH  quotient N/D, Q1.(WIDTH-1); holds until the next accepted start.
- dbz  output  1  divide-by-zero flag; holds like q.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; N_r/D_r/K_r/cnt=0; busy=0, done=0, q=0, dbz=0.
  - Mid-operation reset aborts silently: no done pulse.
- States: IDLE, MUL_N, MUL_D, DONE (2-bit enum).
- IDLE:
  - start=1 and D!=0: N_r<=N, D_r<=D, K_r<=IA, cnt<=0, dbz<=0 -> MUL_N.
  - start=1 and D==0: q<=all-ones, dbz<=1 -> DONE.
  - start=0: stay.
- MUL_N: N_r<=trunc(N_r*K_r) -> MUL_D.
- MUL_D:
  - D_r<=trunc(D_r*K_r).
  - K_r<=(~trunc(D_r*K_r))+1, i.e. 2-D in Q1.(WIDTH-1), wrap mod 2^WIDTH intended.
  - If cnt==ITER-1: q<=trunc(N_r*K_r) from the previous MUL_N result, already in N_r; -> DONE.
  - Else: cnt<=cnt+1 -> MUL_N.
  - q takes N_r, which MUL_N has already updated.
- DONE: done=1 for exactly this cycle -> IDLE.
- busy is 1 in MUL_N, MUL_D and DONE; 0 in IDLE.
- Multiplier is shared:
  - Operand A = N_r in MUL_N, D_r in MUL_D; operand B = K_r.
  - 2*WIDTH-bit unsigned product.
  - trunc() takes product bits [2*WIDTH-2 : WIDTH-1]: truncation, no rounding, no saturation.
- Latency: start sampled at edge 0; done high in cycle 2*ITER+1; next start accepted in the cycle after done. dbz path: done in cycle 1.
- start while busy or in DONE: ignored, no queuing.
- start with N=0: runs normally, q=0.
- Accuracy: |q - exact N/D| <= ITER LSB when |1 - D*IA| < 2^-3.

Decomposition:
- Package goldschmidt_pkg holds:
  - state_t enum {IDLE, MUL_N, MUL_D, DONE};
  - function fx_trunc(product) selecting bits [2W-2:W-1];
  - function two_minus(x) = ~x+1.
- One sub-module: gs_mult, a combinational unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
  - The carry-save array is replaceable later without touching the FSM.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with start=1 -> busy=0, done=0, q=0x0000, dbz=0; release, no done within 10 cycles with start=0.
2. Basic divide (WIDTH=16, ITER=3): N=0x6000, D=0x6000, IA=0xAAAB, start 1 cycle -> done at cycle 7 exactly, q in [0x7FFD,0x8000], dbz=0, busy high cycles 1-7.
3. Extreme divisor: N=0x4000, D=0x4000, IA=0xFFFF -> q in [0x7FFD,0x8000]; then N=0x7FFF, D=0x7FFF, IA=0x8001 -> q in [0x7FFD,0x8000].
4. Divide by zero: D=0x0000, N=0x1234 -> done at cycle 1, q=0xFFFF, dbz=1; next valid divide clears dbz.
5. Handshake: pulse start again at cycles 2 and 7 during an operation -> ignored, exactly one done; start in cycle 8 accepted.
6. Abort and parameter sweep:
   - Assert reset at cycle 4 of a divide -> all outputs 0, no done; a subsequent divide is correct.
   - Repeat scenario 2 with ITER=1 (done at cycle 3) and WIDTH=24.
   - Compare against a reference model over 1000 random legal operands.

Source files
------------

// File: rtl/goldschmidt_div_pkg.sv
// goldschmidt_pkg: shared state encoding and fixed-point helpers for the Goldschmidt divider.
package goldschmidt_pkg;
  typedef enum logic [1:0] {IDLE, MUL_N, MUL_D, DONE} state_t;
  function automatic logic [63:0] fx_trunc(input logic [127:0] p, input int w);
    return 64'(p >> (w - 1));
  endfunction
  function automatic logic [63:0] two_minus(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction
endpackage

// File: rtl/goldschmidt_div_if.sv
// goldschmidt_div_if: start/busy/done handshake and operand/result bus of the divider.
interface goldschmidt_div_if #(parameter int WIDTH = 16);
  logic start, busy, done, dbz;
  logic [WIDTH-1:0] N, D, IA, q;
  modport master(output start, N, D, IA, input busy, done, q, dbz);
  modport slave(input start, N, D, IA, output busy, done, q, dbz);
endinterface

// File: rtl/goldschmidt_div_mult.sv
// gs_mult: combinational unsigned WIDTH x WIDTH -> 2*WIDTH multiplier shared by the N and D updates.
module gs_mult #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);
  assign p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
endmodule

// File: rtl/goldschmidt_div.sv
// goldschmidt_div: iterative Goldschmidt divider, one shared multiplier alternating N and D updates.
module goldschmidt_div import goldschmidt_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int ITER  = 3
) (
  input logic clk,
  input logic reset,
  goldschmidt_div_if.slave bus
);
  state_t state, nxt;
  logic [WIDTH-1:0] n_r, d_r, k_r, t;
  logic [2*WIDTH-1:0] prod;
  logic [3:0] cnt;
  logic last;
  gs_mult #(.WIDTH(WIDTH)) u_mult (.a(state == MUL_D ? d_r : n_r), .b(k_r), .p(prod));
  assign t = WIDTH'(fx_trunc(128'(prod), WIDTH));
  assign last = cnt == 4'(ITER - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = bus.start ? (bus.D == '0 ? DONE : MUL_N) : IDLE;
      MUL_N:   nxt = MUL_D;
      MUL_D:   nxt = last ? DONE : MUL_N;
      default: nxt = IDLE;
    endcase
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      n_r <= '0;
      d_r <= '0;
      k_r <= '0;
      cnt <= '0;
      bus.q <= '0;
      bus.dbz <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (bus.start && bus.D == '0) begin
            bus.q <= '1;
            bus.dbz <= 1'b1;
          end else if (bus.start) begin
            n_r <= bus.N;
            d_r <= bus.D;
            k_r <= bus.IA;
            cnt <= '0;
            bus.dbz <= 1'b0;
          end
        MUL_N: n_r <= t;
        MUL_D: begin
          d_r <= t;
          k_r <= WIDTH'(two_minus(64'(t)));
          if (last) bus.q <= n_r;
          else cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_goldschmidt_div.sv
// tb_goldschmidt_div: directed and random checks of goldschmidt_div against an arithmetic reference.
module tb_goldschmidt_div;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0, passed = 0;
  int m_rem = 0;
  logic [15:0] m_q = '0;
  logic m_dbz = 1'b0;
  goldschmidt_div_if #(.WIDTH(16)) b0 ();
  goldschmidt_div_if #(.WIDTH(24)) b1 ();
  goldschmidt_div #(.WIDTH(16), .ITER(3)) u0 (.clk(clk), .reset(reset), .bus(b0));
  goldschmidt_div #(.WIDTH(24), .ITER(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;

  function automatic logic [63:0] gs_model(input logic [63:0] n, d, k, input int w, it);
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < it; i++) begin
      n = ((n * k) >> (w - 1)) & mask;
      d = ((d * k) >> (w - 1)) & mask;
      k = (~d + 64'd1) & mask;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input logic [63:0] act, input logic [63:0] lo, input logic [63:0] hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0h expected in [%0h,%0h]", nm, act, lo, hi);
  endtask

  // Cycle-level expectation for u0: how many busy cycles remain and what the result must be.
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_rem = 0;
      m_q = '0;
      m_dbz = 1'b0;
    end else if (m_rem > 0) m_rem--;
    else if (b0.start && b0.D == 16'h0) begin
      m_rem = 1;
      m_q = 16'hFFFF;
      m_dbz = 1'b1;
    end else if (b0.start) begin
      m_rem = 7;
      m_q = 16'(gs_model(64'(b0.N), 64'(b0.D), 64'(b0.IA), 16, 3));
      m_dbz = 1'b0;
    end

  always @(negedge clk) begin
    chk("busy", 64'(b0.busy), 64'(m_rem > 0));
    chk("done", 64'(b0.done), 64'(m_rem == 1));
    if (m_rem <= 1) begin
      chk("q", 64'(b0.q), 64'(m_q));
      chk("dbz", 64'(b0.dbz), 64'(m_dbz));
    end
  end

  task automatic go0(input logic [15:0] n, d, ia);
    @(negedge clk);
    b0.start = 1'b1;
    b0.N = n;
    b0.D = d;
    b0.IA = ia;
    @(negedge clk);
    b0.start = 1'b0;
  endtask

  task automatic wait0(output int k);
    k = 1;
    while (!b0.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!b0.done) chk("done_timeout", 64'(k), 64'd0);
  endtask

  initial begin
    int k, nd;
    logic [15:0] n, d, ia;
    b0.start = 1'b1; b0.N = 16'h6000; b0.D = 16'h6000; b0.IA = 16'hAAAB;
    b1.start = 1'b0; b1.N = '0; b1.D = '0; b1.IA = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(b0.busy), 64'd0);
    chk("rst_done", 64'(b0.done), 64'd0);
    chk("rst_q", 64'(b0.q), 64'h0);
    chk("rst_dbz", 64'(b0.dbz), 64'd0);
    b0.start = 1'b0;
    #1 reset = 1'b1;
    nd = 0;
    repeat (10) begin @(negedge clk); nd += int'(b0.done); end
    chk("idle_no_done", 64'(nd), 64'd0);

    go0(16'h6000, 16'h6000, 16'hAAAB);
    chk("busy_c1", 64'(b0.busy), 64'd1);
    wait0(k);
    chk("lat_basic", 64'(k), 64'd7);
    chk("q_basic", 64'(b0.q), 64'h8000);
    chk_rng("q_basic_rng", 64'(b0.q), 64'h7FFD, 64'h8000);

    go0(16'h4000, 16'h4000, 16'hFFFF);
    wait0(k);
    chk_rng("q_dmin", 64'(b0.q), 64'h7FFD, 64'h8000);
    go0(16'h7FFF, 16'h7FFF, 16'h8001);
    wait0(k);
    chk_rng("q_dmax", 64'(b0.q), 64'h7FFD, 64'h8000);

    go0(16'h1234, 16'h0000, 16'h8000);
    wait0(k);
    chk("lat_dbz", 64'(k), 64'd1);
    chk("q_dbz", 64'(b0.q), 64'hFFFF);
    chk("dbz_set", 64'(b0.dbz), 64'd1);
    go0(16'h3000, 16'h6000, 16'hAAAB);
    wait0(k);
    chk("dbz_clear", 64'(b0.dbz), 64'd0);
    chk_rng("q_half", 64'(b0.q), 64'h3FFD, 64'h4000);

    go0(16'h6000, 16'h6000, 16'hAAAB);
    nd = 0;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      nd += int'(b0.done);
      b0.start = (c == 2 || c == 7 || c == 8);
      b0.N = 16'h2000; b0.D = 16'h4000; b0.IA = 16'hFFFF;
    end
    @(negedge clk);
    b0.start = 1'b0;
    chk("one_done", 64'(nd), 64'd1);
    wait0(k);
    chk("lat_c8", 64'(k), 64'd7);
    chk_rng("q_c8", 64'(b0.q), 64'h3FFD, 64'h4000);

    go0(16'h6000, 16'h6000, 16'hAAAB);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 64'(b0.busy), 64'd0);
    chk("abort_done", 64'(b0.done), 64'd0);
    chk("abort_q", 64'(b0.q), 64'h0);
    chk("abort_dbz", 64'(b0.dbz), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    nd = 0;
    repeat (10) begin @(negedge clk); nd += int'(b0.done); end
    chk("abort_no_done", 64'(nd), 64'd0);
    go0(16'h6000, 16'h6000, 16'hAAAB);
    wait0(k);
    chk("q_after_abort", 64'(b0.q), 64'h8000);

    @(negedge clk);
    b1.start = 1'b1; b1.N = 24'h600000; b1.D = 24'h600000; b1.IA = 24'hAAAAAB;
    @(negedge clk);
    b1.start = 1'b0;
    k = 1;
    while (!b1.done && k < 20) begin @(negedge clk); k++; end
    chk("lat_w24", 64'(k), 64'd3);
    chk("q_w24", 64'(b1.q), 64'h800000);
    chk("q_w24_model", 64'(b1.q), gs_model(64'h600000, 64'h600000, 64'hAAAAAB, 24, 1));
    chk("dbz_w24", 64'(b1.dbz), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      n = 16'($urandom_range(0, 32'h7FFF));
      d = 16'($urandom_range(32'h4000, 32'h7FFF));
      ia = (32'h4000_0000 / 32'(d)) > 32'hFFFF ? 16'hFFFF : 16'(32'h4000_0000 / 32'(d));
      go0(n, d, ia);
      wait0(k);
      chk("lat_rand", 64'(k), 64'd7);
      chk("q_rand", 64'(b0.q), gs_model(64'(n), 64'(d), 64'(ia), 16, 3));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
